// File: rtl/lift_obuf_pkg.sv
// -----------------------------------------------------------------------------
// lift_obuf_pkg
// Shared constants, derived widths, FSM state type and the lane-insert helper
// for the lift wrapper output buffer.
// Contents:
//   WIDTH, LANES, DEPTH      : coefficient width, lanes per word, FIFO depth
//   LANE_W, ADDR_W, WORD_W,
//   LEVEL_W                  : derived widths
//   obuf_state_e             : FILL / FLUSH_WAIT (FLUSH_WAIT used only when
//                              LIFT_OBUF_FLUSH_EN is defined)
//   put_lane()               : replace one 30-bit lane of a packed word
// -----------------------------------------------------------------------------
package lift_obuf_pkg;

    localparam int WIDTH   = 30;
    localparam int LANES   = 8;
    localparam int DEPTH   = 64;
    localparam int LANE_W  = 3;
    localparam int ADDR_W  = 6;
    localparam int WORD_W  = WIDTH * LANES;   // 240
    localparam int LEVEL_W = 7;               // holds 0..64

    typedef enum logic [0:0] {
        ST_FILL       = 1'b0,
        ST_FLUSH_WAIT = 1'b1
    } obuf_state_e;

    // Returns word with lane 'lane' replaced by val; all other lanes unchanged.
    function automatic logic [WORD_W-1:0] put_lane(
        input logic [WORD_W-1:0] word,
        input logic [LANE_W-1:0] lane,
        input logic [WIDTH-1:0]  val
    );
        logic [WORD_W-1:0] res;
        res = word;
        for (int k = 0; k < LANES; k++) begin
            res[k*WIDTH +: WIDTH] = (lane == LANE_W'(k)) ? val : res[k*WIDTH +: WIDTH];
        end
        return res;
    endfunction

endpackage

// File: rtl/lift_buffer_ram.sv
// -----------------------------------------------------------------------------
// lift_buffer_ram
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Contents are not reset.
// Ports:
//   clk    : clock, write on rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module lift_buffer_ram #(
    parameter int DATA_W = 30,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lift_wrapper_output_buffer.sv
// -----------------------------------------------------------------------------
// lift_wrapper_output_buffer
// Packs 30-bit lift coefficients (one per cycle) into 240-bit words, lane k in
// bits [30k+29:30k], and queues the words in a 64-deep show-ahead FIFO drained
// by a valid/ready consumer.
// Build option: define LIFT_OBUF_FLUSH_EN to add the flush port, which commits
// a partially filled word (unfilled lanes zero), waiting in FLUSH_WAIT while
// the FIFO is full.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   din        : coefficient input
//   din_valid  : din valid this cycle
//   din_ready  : buffer accepts din this cycle
//   dout       : packed word at FIFO head (zero when empty)
//   dout_valid : FIFO non-empty
//   dout_ready : consumer takes dout this cycle
//   level      : FIFO occupancy in words (0..64)
//   flush      : commit partial word (LIFT_OBUF_FLUSH_EN only)
// -----------------------------------------------------------------------------
module lift_wrapper_output_buffer
    import lift_obuf_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [WORD_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [LEVEL_W-1:0] level
`ifdef LIFT_OBUF_FLUSH_EN
    ,
    input  logic               flush
`endif
);

    logic [LANE_W-1:0]  lane_cnt_r;
    logic [WORD_W-1:0]  asm_r;
    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [LEVEL_W-1:0] count_r;

    logic               full_s;
    logic               last_lane_s;
    logic               accept_s;
    logic               pop_s;
    logic               push_s;
    logic [WORD_W-1:0]  asm_merged_s;
    logic [WORD_W-1:0]  asm_next_s;
    logic [LANE_W-1:0]  lane_next_s;
    logic [WORD_W-1:0]  ram_rdata_s;

`ifdef LIFT_OBUF_FLUSH_EN
    obuf_state_e        state_r;
    obuf_state_e        state_next_s;
`endif

    assign full_s      = (count_r == LEVEL_W'(DEPTH));
    assign last_lane_s = (lane_cnt_r == 3'd7);
    assign dout_valid  = (count_r != {LEVEL_W{1'b0}});
    assign pop_s       = dout_valid & dout_ready;
    assign level       = count_r;

    // Handshake, lane assembly and commit decision (next-state logic)
    always_comb begin
        din_ready = !(full_s && last_lane_s);
`ifdef LIFT_OBUF_FLUSH_EN
        state_next_s = state_r;
        // No new coefficients while a flush is waiting for FIFO space.
        if (state_r != ST_FILL) begin
            din_ready = 1'b0;
        end else begin
            din_ready = din_ready;
        end
`endif
        accept_s     = din_valid & din_ready;
        asm_merged_s = accept_s ? put_lane(asm_r, lane_cnt_r, din) : asm_r;
        asm_next_s   = asm_merged_s;
        lane_next_s  = accept_s ? (lane_cnt_r + 3'd1) : lane_cnt_r;
        push_s       = 1'b0;

`ifdef LIFT_OBUF_FLUSH_EN
        case (state_r)
            ST_FILL: begin
                if (accept_s && last_lane_s) begin
                    push_s      = 1'b1;
                    asm_next_s  = {WORD_W{1'b0}};
                    lane_next_s = 3'd0;
                end else if (flush && ((lane_cnt_r != 3'd0) || accept_s)) begin
                    if (full_s) begin
                        // Keep the merged partial word; commit once space frees.
                        state_next_s = ST_FLUSH_WAIT;
                    end else begin
                        push_s      = 1'b1;
                        asm_next_s  = {WORD_W{1'b0}};
                        lane_next_s = 3'd0;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!full_s) begin
                    push_s       = 1'b1;
                    asm_next_s   = {WORD_W{1'b0}};
                    lane_next_s  = 3'd0;
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_FLUSH_WAIT;
                end
            end
            default: begin
                state_next_s = ST_FILL;
            end
        endcase
`else
        if (accept_s && last_lane_s) begin
            push_s      = 1'b1;
            asm_next_s  = {WORD_W{1'b0}};
            lane_next_s = 3'd0;
        end else begin
            push_s = 1'b0;
        end
`endif
    end

`ifdef LIFT_OBUF_FLUSH_EN
    // Flush FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end
`endif

    // Assembly register, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt_r <= 3'd0;
            asm_r      <= {WORD_W{1'b0}};
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {LEVEL_W{1'b0}};
        end else begin
            lane_cnt_r <= lane_next_s;
            asm_r      <= asm_next_s;
            // Pointers wrap 63 -> 0 through natural 6-bit overflow.
            wr_ptr_r   <= push_s ? (wr_ptr_r + 6'd1) : wr_ptr_r;
            rd_ptr_r   <= pop_s  ? (rd_ptr_r + 6'd1) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 7'd1;
                2'b01:   count_r <= count_r - 7'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // One RAM per lane; all share address and write enable.
    for (genvar k = 0; k < LANES; k++) begin : g_lane_ram
        lift_buffer_ram #(
            .DATA_W (WIDTH),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (push_s),
            .waddr (wr_ptr_r),
            .wdata (asm_merged_s[k*WIDTH +: WIDTH]),
            .raddr (rd_ptr_r),
            .rdata (ram_rdata_s[k*WIDTH +: WIDTH])
        );
    end

    assign dout = dout_valid ? ram_rdata_s : {WORD_W{1'b0}};

endmodule

// File: tb/tb_lift_wrapper_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_lift_wrapper_output_buffer
// Self-checking bench for lift_wrapper_output_buffer. A queue-based model
// (list of partial coefficients + list of packed words) predicts din_ready,
// dout_valid, dout and level every cycle. Define LIFT_OBUF_FLUSH_EN for both
// the RTL and this bench to exercise the flush option.
// -----------------------------------------------------------------------------
module tb_lift_wrapper_output_buffer;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [29:0]    din;
    logic           din_valid;
    logic           din_ready;
    logic [239:0]   dout;
    logic           dout_valid;
    logic           dout_ready;
    logic [6:0]     level;
`ifdef LIFT_OBUF_FLUSH_EN
    logic           flush;
`endif

    always #5 clk = ~clk;

    lift_wrapper_output_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level)
`ifdef LIFT_OBUF_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Reference model: coefficients waiting for a word, and committed words.
    bit [29:0]  part[$];
    bit [239:0] q[$];
    bit         pend;
    int         max_level;

    function automatic bit [239:0] pack_part();
        bit [239:0] w;
        w = '0;
        foreach (part[i]) w[30*i +: 30] = part[i];
        return w;
    endfunction

    task automatic chk(input string name, input logic [239:0] got, input logic [239:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic chk_outputs();
        chk("dout_valid", dout_valid, (q.size() != 0));
        chk("level", level, q.size());
        chk("dout", dout, (q.size() != 0) ? q[0] : 240'd0);
        if (q.size() > max_level) max_level = q.size();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
`ifdef LIFT_OBUF_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        part.delete(); q.delete(); pend = 1'b0; max_level = 0;
        chk_outputs();
        chk("reset_din_ready", din_ready, 1'b1);
    endtask

    // One clock: drive inputs, predict, advance, compare.
    task automatic step(input bit v, input bit [29:0] d, input bit rdy, input bit fl);
        bit exp_rdy, acc, pp;
        int pre;
        din_valid = v; din = d; dout_ready = rdy;
`ifdef LIFT_OBUF_FLUSH_EN
        flush = fl;
`endif
        pre     = q.size();
        exp_rdy = !pend && !(pre == 64 && part.size() == 7);
        chk("din_ready", din_ready, exp_rdy);
        acc = v && exp_rdy;
        pp  = rdy && (pre > 0);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) part.push_back(d);
        if (acc && part.size() == 8) begin
            q.push_back(pack_part());
            part.delete();
        end
`ifdef LIFT_OBUF_FLUSH_EN
        else if (pend) begin
            if (pre < 64) begin
                q.push_back(pack_part()); part.delete(); pend = 1'b0;
            end
        end else if (fl && part.size() != 0) begin
            if (pre < 64) begin
                q.push_back(pack_part()); part.delete();
            end else begin
                pend = 1'b1;
            end
        end
`else
        if (fl) pend = pend;
`endif
        #1;
        chk_outputs();
    endtask

    typedef struct {
        bit        v;
        bit [29:0] d;
        bit        rdy;
        int        exp_level;
        bit        exp_valid;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Test 1 vectors: din=1..8 with no consumer, then one pop and an idle.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 30'(i + 1), 1'b0, (i == 7) ? 1 : 0, (i == 7)};
        tbl[8] = '{1'b0, 30'd0, 1'b1, 0, 1'b0};
        tbl[9] = '{1'b0, 30'd0, 1'b0, 0, 1'b0};

        // ---- Test 1: first word
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
            chk("t1_level", level, tbl[i].exp_level);
            chk("t1_valid", dout_valid, tbl[i].exp_valid);
            if (i == 7) begin
                chk("t1_lane0", dout[29:0], 30'd1);
                chk("t1_lane7", dout[239:210], 30'd8);
            end
        end

        // ---- Test 2: fill to 64, lane 7 of word 65 blocked until a pop
        do_reset();
        for (int w = 0; w < 64; w++)
            for (int l = 0; l < 8; l++) step(1'b1, 30'($urandom), 1'b0, 1'b0);
        chk("t2_full_level", level, 7'd64);
        for (int l = 0; l < 7; l++) step(1'b1, 30'($urandom), 1'b0, 1'b0);
        chk("t2_lane7_blocked", din_ready, 1'b0);
        step(1'b1, 30'h123, 1'b0, 1'b0);
        step(1'b1, 30'h123, 1'b1, 1'b0);
        chk("t2_after_pop_level", level, 7'd63);
        chk("t2_after_pop_ready", din_ready, 1'b1);
        step(1'b1, 30'h123, 1'b0, 1'b0);
        chk("t2_refill_level", level, 7'd64);

        // ---- Test 3: streaming through pointer wrap
        do_reset();
        for (int w = 0; w < 200; w++)
            for (int l = 0; l < 8; l++) step(1'b1, 30'(8 * w + l), 1'b1, 1'b0);
        chk("t3_max_level", (max_level <= 1), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 30'd0, 1'b1, 1'b0);

        // ---- Test 4: push and pop together at level 10
        do_reset();
        for (int w = 0; w < 10; w++)
            for (int l = 0; l < 8; l++) step(1'b1, 30'(100 + 8 * w + l), 1'b0, 1'b0);
        chk("t4_level10", level, 7'd10);
        chk("t4_head_w0", dout[29:0], 30'd100);
        for (int l = 0; l < 7; l++) step(1'b1, 30'(180 + l), 1'b0, 1'b0);
        step(1'b1, 30'd187, 1'b1, 1'b0);
        chk("t4_level_kept", level, 7'd10);
        chk("t4_head_w1", dout[29:0], 30'd108);

        // ---- Test 5: reset mid-word discards everything
        do_reset();
        for (int l = 0; l < 3; l++) step(1'b1, 30'(900 + l), 1'b0, 1'b0);
        step(1'b0, 30'd0, 1'b0, 1'b0);
        do_reset();
        chk("t5_level", level, 7'd0);
        chk("t5_dout", dout, 240'd0);
        for (int l = 0; l < 8; l++) step(1'b1, 30'(500 + l), 1'b0, 1'b0);
        chk("t5_lane0", dout[29:0], 30'd500);
        chk("t5_level1", level, 7'd1);

`ifdef LIFT_OBUF_FLUSH_EN
        // ---- Test 6: flush partial word, then flush while full
        begin
            bit [239:0] expw;
            expw = '0;
            expw[29:0] = 30'hA; expw[59:30] = 30'hB; expw[89:60] = 30'hC;
            do_reset();
            step(1'b1, 30'hA, 1'b0, 1'b0);
            step(1'b1, 30'hB, 1'b0, 1'b0);
            step(1'b1, 30'hC, 1'b0, 1'b0);
            step(1'b0, 30'd0, 1'b0, 1'b1);
            chk("t6_flush_word", dout, expw);
            chk("t6_flush_level", level, 7'd1);
            for (int w = 0; w < 63; w++)
                for (int l = 0; l < 8; l++) step(1'b1, 30'($urandom), 1'b0, 1'b0);
            step(1'b1, 30'hA, 1'b0, 1'b0);
            step(1'b1, 30'hB, 1'b0, 1'b0);
            step(1'b1, 30'hC, 1'b0, 1'b1);
            chk("t6_wait_ready", din_ready, 1'b0);
            step(1'b1, 30'h5, 1'b0, 1'b0);
            step(1'b0, 30'd0, 1'b1, 1'b0);
            chk("t6_wait_pop_level", level, 7'd63);
            step(1'b0, 30'd0, 1'b0, 1'b0);
            chk("t6_commit_level", level, 7'd64);
            chk("t6_ready_back", din_ready, 1'b1);
        end
`endif

        // ---- Random phase: slow then fast consumer
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 30'($urandom),
                 (i < 1500) ? (($urandom % 16) == 0) : (($urandom % 2) == 0),
                 ($urandom % 32) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
